data_mem_io: RTL and testbench
==============================

# data_mem_io

Memory-side stage of the pipelined core: consumes the M-stage store/address/data outputs and returns same-cycle read data to the M/W boundary. Decodes the address into a word RAM, a byte-wide transmit FIFO with valid/ready drain port, a status register and a free-running cycle counter. All writes commit on the clock edge; all reads are combinational.

## Interface
- DATA_WIDTH, 32: core data width; ReadDataM/WriteDataM width.
- RAM_WORDS, 64: RAM depth in words; power of two.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, at least 2.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- MemWriteM  in  1  store strobe for the current M-stage access.
- ALUOutM  in  2*DATA_WIDTH  M-stage ALU result; bits [31:0] are the byte address, upper half ignored.
- WriteDataM  in  DATA_WIDTH  store data.
- ReadDataM  out  DATA_WIDTH  combinational load data for the current address.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data this cycle.

## Operation
- Address A = ALUOutM[31:0]; A[1:0] ignored (word accesses only).
- A < RAM_WORDS*4: RAM word A[2 +: log2(RAM_WORDS)]. Store writes WriteDataM. Load returns the stored word.
- A = 0x8000_0000 TXDATA: store pushes WriteDataM[7:0]. Load returns 0.
- A = 0x8000_0004 STATUS, read: bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] occupancy count, all other bits 0. A store with WriteDataM[2]=1 clears overflow; other bits are ignored.
- A = 0x8000_0008 CYCLE: load returns the counter. A store loads WriteDataM.
- Any other address: load returns 0 and a store has no effect.
- Push when full with no pop in the same cycle: byte dropped, overflow set.
- Pop on tx_valid && tx_ready.
- Push and pop in the same cycle when full: both succeed and the count is unchanged. The pop frees the slot first.
- Push to an empty FIFO: tx_valid stays 0 that cycle and rises the next cycle. There is no bypass.
- Overflow set and clear in the same cycle: set wins.
- tx_data = 0 whenever the FIFO is empty.

## Timing
- Reset, asynchronous:
  - FIFO empty, pointers and count 0.
  - overflow 0, counter 0.
  - tx_valid 0, tx_data 0.
  - RAM contents are not reset.
- ReadDataM is purely combinational from A and the current state. No latency.
- A load in the same cycle as a store to the same location returns the old value. The new value is visible the next cycle.
- Counter increments every cycle and wraps 0xFFFF_FFFF → 0. A store takes priority over the increment: the next cycle reads the written value, and it increments after that.
- tx_data/tx_valid are registered-state outputs. They change only after a clock edge or reset.
- Reset asserted mid-transfer discards FIFO contents immediately. tx_valid drops without waiting for a clock.

## Configuration
- DMEM_CYCLE_COUNTER_EN
- Defined: CYCLE register present as described above.
- Undefined: no counter flops; 0x8000_0008 reads 0 and stores there are ignored, like any unmapped address.

## Structure
- Package dmem_pkg holds:
  - address constants for RAM_BASE, TXDATA, STATUS and CYCLE;
  - STATUS bit indices (full, empty, overflow, count field LSB/MSB).
- Sub-module sync_fifo (parameters WIDTH, DEPTH) implements the TX FIFO:
  - push/pop/full/empty/count ports;
  - pop-before-push full semantics;
  - async active-high reset.
- The top does the address decode, RAM, status/overflow and counter.

## Test plan
- After reset: load 0x8000_0004 returns 0x0000_0002; tx_valid 0; load 0x8000_0008 returns 0 in the first cycle and 1 one cycle later.
- Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 → 0xDEADBEEF; load 0x0000_0013 → same word; load 0x0000_1000 → 0.
- Push 0x41, 0x42, 0x43 with tx_ready=0 → STATUS reads 0x0000_0300, tx_data 0x41. Raise tx_ready → bytes 41, 42, 43 drain on successive cycles, then tx_valid 0.
- Push 9 bytes with tx_ready=0 (depth 8) → STATUS = 0x0000_0805 (count 8, full, overflow); 9th byte is absent from the drain. Store 0x4 to STATUS → overflow cleared, STATUS = 0x0000_0801.
- Full FIFO with tx_ready=1 and a push in the same cycle → count stays 8, no overflow, pushed byte drains last.
- Store 0xFFFF_FFFE to CYCLE → reads 0xFFFF_FFFE next cycle, then 0xFFFF_FFFF, then 0. With DMEM_CYCLE_COUNTER_EN undefined, all reads of CYCLE return 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory stage: memory-map addresses and STATUS layout.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package dmem_pkg;

  // Memory map (byte addresses; the low two bits are ignored on decode)
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
  localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0008;

  // STATUS register layout
  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_OVF_BIT   = 2;
  localparam int ST_CNT_LSB   = 8;
  localparam int ST_CNT_MSB   = 15;

  // Only word accesses exist, so every decode works on the word-aligned address.
  function automatic logic [31:0] wordAlign(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with pop-before-push semantics when full; head is zero when empty.
// Latency: a push is visible at the head one cycle later (no bypass).
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   push, pushData    write strobe and data
//   pop               read strobe (ignored while empty)
//   popData           head entry, zero while empty
//   full, empty       occupancy flags
//   count             number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             popOk;
  logic             pushOk;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees its slot before the push is considered, so a full FIFO can
  // accept a push in the same cycle it is drained.
  assign popOk  = pop && !empty;
  assign pushOk = push && (!full || popOk);

  // Storage is not reset; the empty mask on popData hides stale entries.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PW'(1);
      if (popOk)  rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(pushOk) - CW'(popOk);
    end
  end

  assign popData = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/data_mem_io.sv
// M-stage data memory: word RAM, byte TX FIFO, STATUS register and optional cycle counter.
// Latency: loads are combinational (0 cycles); stores commit on the clock edge.
// Backpressure: TX drains on tx_valid && tx_ready; stores to a full FIFO are dropped and set overflow.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   MemWriteM           store strobe
//   ALUOutM             M-stage ALU result; [31:0] is the byte address
//   WriteDataM          store data
//   ReadDataM           combinational load data
//   tx_data, tx_valid   FIFO head byte / non-empty
//   tx_ready            consumer accepts tx_data this cycle
//
// Build option: define DMEM_CYCLE_COUNTER_EN to include the free-running CYCLE register;
// without it 0x8000_0008 behaves as an unmapped address.
module data_mem_io
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemWriteM,
  input  logic [2*DATA_WIDTH-1:0] ALUOutM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  output logic [DATA_WIDTH-1:0]   ReadDataM,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam int          ST_CNT_W  = ST_CNT_MSB - ST_CNT_LSB + 1;

  // ---------------- address decode ----------------
  logic [31:0] addrWord;
  logic [31:0] ramOffset;
  logic        isRam;
  logic        isTx;
  logic        isStatus;
  logic        unusedAluHi;

  assign addrWord  = wordAlign(ALUOutM[31:0]);
  assign ramOffset = addrWord - RAM_BASE;
  assign isRam     = (ramOffset < RAM_BYTES);
  assign isTx      = (addrWord == TXDATA_ADDR);
  assign isStatus  = (addrWord == STATUS_ADDR);

  // The upper half of the ALU result carries no address information.
  assign unusedAluHi = ^ALUOutM[2*DATA_WIDTH-1:32];

  // ---------------- word RAM (not reset) ----------------
  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
  logic [RAM_AW-1:0]     ramIdx;

  assign ramIdx = ramOffset[2 +: RAM_AW];

  always_ff @(posedge clk) begin
    if (MemWriteM && isRam) begin
      ram[ramIdx] <= WriteDataM;
    end
  end

  // ---------------- TX FIFO ----------------
  logic             fifoPush;
  logic             fifoPop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CNT_W-1:0] fifoCount;
  logic [7:0]       fifoHead;

  assign fifoPush = MemWriteM && isTx;
  assign fifoPop  = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) uTxFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifoPush),
    .pushData (WriteDataM[7:0]),
    .pop      (fifoPop),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign tx_valid = !fifoEmpty;
  assign tx_data  = fifoHead;

  // ---------------- sticky overflow ----------------
  logic overflow;
  logic ovfSet;
  logic ovfClr;

  // A concurrent pop makes room, so that push is not an overflow.
  assign ovfSet = fifoPush && fifoFull && !fifoPop;
  assign ovfClr = MemWriteM && isStatus && WriteDataM[ST_OVF_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovfSet) begin
      overflow <= 1'b1;
    end else if (ovfClr) begin
      overflow <= 1'b0;
    end
  end

  logic [DATA_WIDTH-1:0] statusWord;

  always_comb begin
    statusWord                          = '0;
    statusWord[ST_FULL_BIT]             = fifoFull;
    statusWord[ST_EMPTY_BIT]            = fifoEmpty;
    statusWord[ST_OVF_BIT]              = overflow;
    statusWord[ST_CNT_MSB:ST_CNT_LSB]   = ST_CNT_W'(fifoCount);
  end

  // ---------------- cycle counter ----------------
  logic [DATA_WIDTH-1:0] cycleValue;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic                  isCycle;
  logic [DATA_WIDTH-1:0] cycleCount;

  assign isCycle = (addrWord == CYCLE_ADDR);

  // A store wins over the increment; counting resumes on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCount <= '0;
    end else if (MemWriteM && isCycle) begin
      cycleCount <= WriteDataM;
    end else begin
      cycleCount <= cycleCount + DATA_WIDTH'(1);
    end
  end

  assign cycleValue = isCycle ? cycleCount : '0;
`else
  assign cycleValue = '0;
`endif

  // ---------------- load mux ----------------
  // TXDATA and unmapped addresses read as zero; cycleValue is already zero
  // unless the counter is selected.
  always_comb begin
    ReadDataM = cycleValue;
    if (isRam) begin
      ReadDataM = ram[ramIdx];
    end else if (isStatus) begin
      ReadDataM = statusWord;
    end
  end

endmodule

// File: tb/tb_data_mem_io.sv
// Bench for data_mem_io: reset checks, a directed vector table, cycle-counter and
// mid-transfer-reset sequences, then randomized traffic against a queue-based model.
module tb_data_mem_io;

  localparam int DW    = 32;
  localparam int WORDS = 64;
  localparam int DEPTH = 8;

  localparam logic [31:0] TX = 32'h8000_0000;
  localparam logic [31:0] ST = 32'h8000_0004;
  localparam logic [31:0] CY = 32'h8000_0008;

  logic            clk = 1'b0;
  logic            reset;
  logic            MemWriteM;
  logic [2*DW-1:0] ALUOutM;
  logic [DW-1:0]   WriteDataM;
  logic [DW-1:0]   ReadDataM;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;

  int checks   = 0;
  int failures = 0;

  data_mem_io #(.DATA_WIDTH(DW), .RAM_WORDS(WORDS), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        tr;
    logic        chkRd;
    logic [31:0] expRd;
    logic        expV;
    logic [7:0]  expD;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic mw, input logic [31:0] addr, input logic [31:0] wd,
                              input logic tr, input logic chkRd, input logic [31:0] expRd,
                              input logic expV, input logic [7:0] expD);
    vec_t v;
    v.mw = mw; v.addr = addr; v.wd = wd; v.tr = tr;
    v.chkRd = chkRd; v.expRd = expRd; v.expV = expV; v.expD = expD;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Upper half of ALUOutM gets random junk to show it is ignored.
  task automatic setIn(input logic mw, input logic [31:0] a, input logic [31:0] wd, input logic tr);
    MemWriteM  = mw;
    ALUOutM    = {$urandom(), a};
    WriteDataM = wd;
    tx_ready   = tr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mRam [WORDS];
  bit          mKnown [WORDS];
  logic [7:0]  mQ[$];
  bit          mOvf;
  logic [31:0] mCnt;

  function automatic logic [31:0] cycleExp(input logic [31:0] v);
`ifdef DMEM_CYCLE_COUNTER_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    logic [31:0] a, wd, aw, expRd;
    logic        mw, tr, known;
    int          sel;

    reset = 1'b1;
    setIn(1'b0, ST, 32'h0, 1'b0);
    #2;
    chk("status_in_reset", ReadDataM, 32'h2);
    chk("valid_in_reset", {31'h0, tx_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // ---- post-reset: counter 0 then 1, STATUS empty ----
    setIn(1'b0, CY, 32'h0, 1'b0);
    #4;
    chk("cycle_first", ReadDataM, 32'h0);
    chk("reset_valid", {31'h0, tx_valid}, 32'h0);
    chk("reset_data", {24'h0, tx_data}, 32'h0);
    nextCycle();
    #4;
    chk("cycle_second", ReadDataM, cycleExp(32'h1));
    nextCycle();
    setIn(1'b0, ST, 32'h0, 1'b0);
    #4;
    chk("reset_status", ReadDataM, 32'h2);
    nextCycle();

    // ---- directed table ----
    add(1, 32'h10,   32'hDEADBEEF, 0, 0, 32'h0,        0, 8'h00);
    add(0, 32'h10,   32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h00);
    add(0, 32'h13,   32'h0,        0, 1, 32'hDEADBEEF, 0, 8'h00);
    add(0, 32'h1000, 32'h0,        0, 1, 32'h0,        0, 8'h00);
    add(1, TX,       32'hFFFFFF41, 0, 1, 32'h0,        0, 8'h00); // no bypass
    add(1, TX,       32'h42,       0, 1, 32'h0,        1, 8'h41);
    add(1, TX,       32'h43,       0, 1, 32'h0,        1, 8'h41);
    add(0, ST,       32'h0,        0, 1, 32'h300,      1, 8'h41);
    add(0, 32'h1000, 32'h0,        1, 1, 32'h0,        1, 8'h41);
    add(0, 32'h1000, 32'h0,        1, 1, 32'h0,        1, 8'h42);
    add(0, 32'h1000, 32'h0,        1, 1, 32'h0,        1, 8'h43);
    add(0, ST,       32'h0,        1, 1, 32'h2,        0, 8'h00);
    for (int i = 0; i < 9; i++)
      add(1, TX, 32'h50 + i, 0, 1, 32'h0, (i > 0), (i > 0) ? 8'h50 : 8'h00);
    add(0, ST,       32'h0,        0, 1, 32'h805,      1, 8'h50);
    add(1, ST,       32'h4,        0, 1, 32'h805,      1, 8'h50); // old value this cycle
    add(0, ST,       32'h0,        0, 1, 32'h801,      1, 8'h50);
    add(1, TX,       32'h60,       1, 1, 32'h0,        1, 8'h50); // push+pop at full
    add(0, ST,       32'h0,        0, 1, 32'h801,      1, 8'h51);
    for (int k = 0; k < 8; k++)
      add(0, 32'h1000, 32'h0, 1, 1, 32'h0, 1, (k < 7) ? 8'(8'h51 + k) : 8'h60);
    add(0, ST,       32'h0,        0, 1, 32'h2,        0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      setIn(vecs[i].mw, vecs[i].addr, vecs[i].wd, vecs[i].tr);
      #4;
      if (vecs[i].chkRd) chk($sformatf("vec%0d_rd", i), ReadDataM, vecs[i].expRd);
      chk($sformatf("vec%0d_valid", i), {31'h0, tx_valid}, {31'h0, vecs[i].expV});
      chk($sformatf("vec%0d_data", i), {24'h0, tx_data}, {24'h0, vecs[i].expD});
      nextCycle();
    end

    // ---- cycle counter store and wrap ----
    setIn(1'b1, CY, 32'hFFFF_FFFE, 1'b0);
    nextCycle();
    setIn(1'b0, CY, 32'h0, 1'b0);
    #4;
    chk("cycle_loaded", ReadDataM, cycleExp(32'hFFFF_FFFE));
    nextCycle();
    #4;
    chk("cycle_max", ReadDataM, cycleExp(32'hFFFF_FFFF));
    nextCycle();
    #4;
    chk("cycle_wrap", ReadDataM, 32'h0);
    nextCycle();

    // ---- reset mid-transfer drops tx_valid without a clock ----
    setIn(1'b1, TX, 32'h77, 1'b0);
    nextCycle();
    setIn(1'b1, TX, 32'h78, 1'b0);
    nextCycle();
    setIn(1'b0, ST, 32'h0, 1'b0);
    #1;
    chk("pre_reset_valid", {31'h0, tx_valid}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", {31'h0, tx_valid}, 32'h0);
    chk("async_reset_data", {24'h0, tx_data}, 32'h0);
    chk("async_reset_status", ReadDataM, 32'h2);
    nextCycle();
    reset = 1'b0;
    mQ.delete();
    mOvf = 1'b0;
    mCnt = 32'h0;
    for (int i = 0; i < WORDS; i++) mKnown[i] = 1'b0;

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    a = $urandom_range(0, WORDS * 4 - 1);
        2, 3, 4: a = TX | $urandom_range(0, 3);
        5:       a = ST;
        6:       a = CY;
        7:       a = 32'h0000_0100 + $urandom_range(0, 255);
        default: a = 32'h8000_000C;
      endcase
      mw = ($urandom_range(0, 2) != 0);
      wd = $urandom();
      if (sel == 6 && $urandom_range(0, 3) != 0) mw = 1'b0;
      tr = ($urandom_range(0, 2) == 0);
      setIn(mw, a, wd, tr);
      #4;

      aw    = {a[31:2], 2'b00};
      known = 1'b1;
      if (aw < WORDS * 4) begin
        known = mKnown[aw[7:2]];
        expRd = mRam[aw[7:2]];
      end else if (aw == ST) begin
        expRd = {16'h0, 8'(mQ.size()), 5'h0, mOvf, (mQ.size() == 0), (mQ.size() == DEPTH)};
      end else if (aw == CY) begin
        expRd = cycleExp(mCnt);
      end else begin
        expRd = 32'h0;
      end
      if (known) chk($sformatf("rnd%0d_rd", n), ReadDataM, expRd);
      chk($sformatf("rnd%0d_valid", n), {31'h0, tx_valid}, {31'h0, (mQ.size() != 0)});
      chk($sformatf("rnd%0d_data", n), {24'h0, tx_data},
          (mQ.size() != 0) ? {24'h0, mQ[0]} : 32'h0);

      // edge update: pop first, then push, overflow set beats clear
      if (tr && mQ.size() != 0) void'(mQ.pop_front());
      if (mw && aw < WORDS * 4) begin
        mRam[aw[7:2]]   = wd;
        mKnown[aw[7:2]] = 1'b1;
      end
      if (mw && aw == ST && wd[2]) mOvf = 1'b0;
      if (mw && aw == TX) begin
        if (mQ.size() < DEPTH) mQ.push_back(wd[7:0]);
        else mOvf = 1'b1;
      end
      if (mw && aw == CY) mCnt = wd;
      else mCnt = mCnt + 32'h1;
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
